pwl_settle_monitor: RTL and testbench

- Clocked reader for the PWL output of the reset-capable linear filter.
- On `start`, it drives the filter's reset request for a fixed precharge window, then releases it.
- It then samples the filter output every clock edge and declares settling after N consecutive in-tolerance samples, or a timeout.
- Sits between testbench/calibration digital logic and the filter: it generates `reset` for the filter and returns digital status.

---
 rtl/pwl_settle_monitor.sv | 125 ++++++++++++
 tb/tb_pwl_settle_monitor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pwl_settle_monitor.sv
// Settling monitor for a resettable filter: holds the filter in reset for a precharge
// window, then watches its output until N_SETTLE consecutive in-tolerance samples or a timeout.
`timescale 1ns/1ps
module pwl_settle_monitor #(
  parameter int  N_PRE       = 2,
  parameter int  N_SETTLE    = 4,
  parameter int  N_TIMEOUT   = 1000,
  parameter real ABS_TOL_MIN = 1e-6
) (
  input  logic        clk,
  input  logic        reset,
  input  real         in,
  input  real         target,
  input  real         tol,
  input  logic        start,
  output logic        rst_req,
  output real         sample,
  output logic        busy,
  output logic        done,
  output logic        timed_out,
  output logic [31:0] settle_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_TRACK,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t      state, state_n;
  logic [31:0] pre_cnt, pre_cnt_n;
  logic [31:0] trk_cnt, trk_cnt_n;
  logic [31:0] ok_cnt, ok_cnt_n;
  logic        done_n, timed_out_n;
  logic [31:0] settle_cycles_n;
  logic        hit;

  // NaN and non-positive tolerances fail the comparison and fall back to the floor.
  function automatic real eff_tol(input real t);
    return (t > ABS_TOL_MIN) ? t : ABS_TOL_MIN;
  endfunction

  function automatic logic in_tol(input real v, input real tg, input real tl);
    real err;
    err = v - tg;
    if (err < 0.0) err = -err;
    return (err <= eff_tol(tl));
  endfunction

  always_comb begin
    state_n         = state;
    pre_cnt_n       = pre_cnt;
    trk_cnt_n       = trk_cnt;
    ok_cnt_n        = ok_cnt;
    done_n          = done;
    timed_out_n     = timed_out;
    settle_cycles_n = settle_cycles;
    hit             = in_tol(in, target, tol);
    case (state)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (start) begin
          state_n         = S_PRE;
          pre_cnt_n       = '0;
          done_n          = 1'b0;
          timed_out_n     = 1'b0;
          settle_cycles_n = '0;
        end
      end
      S_PRE: begin
        if (pre_cnt == 32'(N_PRE - 1)) begin
          state_n   = S_TRACK;
          trk_cnt_n = '0;
          ok_cnt_n  = '0;
        end else begin
          pre_cnt_n = pre_cnt + 32'd1;
        end
      end
      S_TRACK: begin
        trk_cnt_n = (trk_cnt < 32'(N_TIMEOUT)) ? trk_cnt + 32'd1 : trk_cnt;
        if (hit) ok_cnt_n = (ok_cnt < 32'(N_SETTLE)) ? ok_cnt + 32'd1 : ok_cnt;
        else     ok_cnt_n = '0;
        // A completed streak wins over a coincident timeout.
        if (hit && (ok_cnt + 32'd1 >= 32'(N_SETTLE))) begin
          state_n         = S_DONE;
          done_n          = 1'b1;
          settle_cycles_n = trk_cnt + 32'd1;
        end else if (trk_cnt + 32'd1 >= 32'(N_TIMEOUT)) begin
          state_n         = S_TIMEOUT;
          timed_out_n     = 1'b1;
          settle_cycles_n = 32'(N_TIMEOUT);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      pre_cnt       <= '0;
      trk_cnt       <= '0;
      ok_cnt        <= '0;
      rst_req       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timed_out     <= 1'b0;
      settle_cycles <= '0;
      sample        <= 0.0;
    end else begin
      state         <= state_n;
      pre_cnt       <= pre_cnt_n;
      trk_cnt       <= trk_cnt_n;
      ok_cnt        <= ok_cnt_n;
      rst_req       <= (state_n == S_PRE);
      busy          <= (state_n == S_PRE) || (state_n == S_TRACK);
      done          <= done_n;
      timed_out     <= timed_out_n;
      settle_cycles <= settle_cycles_n;
      sample        <= in;
    end
  end

endmodule

// File: tb/tb_pwl_settle_monitor.sv
// Bench for pwl_settle_monitor: directed and randomized measurements against a streak model.
`timescale 1ns/1ps
module tb_pwl_settle_monitor;

  localparam int NPRE = 2;
  localparam int NSET = 4;
  localparam int NTO  = 1000;
  localparam int NTO2 = 20;

  logic        clk = 1'b0;
  logic        reset, start, start2;
  real         in_v, target_v, tol_v, in2, target2, tol2;
  logic        rst_req, busy, done, timed_out;
  logic        rst_req2, busy2, done2, timed_out2;
  real         sample, sample2;
  logic [31:0] settle_cycles, settle_cycles2;

  int  total = 0;
  int  bad   = 0;
  real trk_vals[$];
  real pre_val;

  always #5 clk = ~clk;

  pwl_settle_monitor #(.N_PRE(NPRE), .N_SETTLE(NSET), .N_TIMEOUT(NTO), .ABS_TOL_MIN(1e-6)) u_dut (
    .clk(clk), .reset(reset), .in(in_v), .target(target_v), .tol(tol_v), .start(start),
    .rst_req(rst_req), .sample(sample), .busy(busy), .done(done), .timed_out(timed_out),
    .settle_cycles(settle_cycles));

  pwl_settle_monitor #(.N_PRE(NPRE), .N_SETTLE(NSET), .N_TIMEOUT(NTO2), .ABS_TOL_MIN(1e-6)) u_to (
    .clk(clk), .reset(reset), .in(in2), .target(target2), .tol(tol2), .start(start2),
    .rst_req(rst_req2), .sample(sample2), .busy(busy2), .done(done2), .timed_out(timed_out2),
    .settle_cycles(settle_cycles2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_real(input string tag, input real obs, input real exp);
    total++;
    assert ($realtobits(obs) === $realtobits(exp)) else begin
      bad++;
      $error("FAIL %s observed=%g expected=%g", tag, obs, exp);
    end
  endtask

  function automatic bit ref_hit(input real v, input real tg, input real tl);
    real lim, d;
    lim = (tl > 1e-6) ? tl : 1e-6;
    d   = (v > tg) ? v - tg : tg - v;
    return d <= lim;
  endfunction

  function automatic real trk_val(input int i);
    return (i < trk_vals.size()) ? trk_vals[i] : trk_vals[trk_vals.size() - 1];
  endfunction

  // One measurement: the model predicts how many TRACK samples end it and how.
  task automatic measure(input string tag, input real tgt, input real tl, input int stray,
                         output int done_cyc, output int sc_out);
    int  exp_n, streak, cyc;
    bit  exp_done;
    streak = 0; exp_done = 0; exp_n = NTO; done_cyc = -1;
    for (int i = 0; i < NTO; i++) begin
      if (ref_hit(trk_val(i), tgt, tl)) streak++; else streak = 0;
      if (streak == NSET) begin exp_done = 1; exp_n = i + 1; break; end
    end
    target_v = tgt; tol_v = tl; in_v = pre_val; start = 1'b1; cyc = 0;
    @(negedge clk); start = 1'b0; cyc++;
    chk({tag, " done_cleared"}, 32'(done), 0);
    chk({tag, " timed_out_cleared"}, 32'(timed_out), 0);
    chk({tag, " settle_cleared"}, settle_cycles, 0);
    for (int p = 0; p < NPRE; p++) begin
      chk({tag, " rst_req_pre"}, 32'(rst_req), 1);
      chk({tag, " busy_pre"}, 32'(busy), 1);
      @(negedge clk); cyc++;
    end
    chk({tag, " rst_req_released"}, 32'(rst_req), 0);
    chk({tag, " busy_track"}, 32'(busy), 1);
    for (int i = 0; i < exp_n; i++) begin
      in_v = trk_val(i);
      if (i == stray) start = 1'b1;
      @(negedge clk); cyc++; start = 1'b0;
      chk_real({tag, " sample"}, sample, in_v);
      if (done && done_cyc < 0) done_cyc = cyc;
      if (i < exp_n - 1) begin
        chk({tag, " busy_mid"}, 32'(busy), 1);
        chk({tag, " done_early"}, 32'(done | timed_out), 0);
      end
    end
    chk({tag, " done"}, 32'(done), 32'(exp_done));
    chk({tag, " timed_out"}, 32'(timed_out), 32'(!exp_done));
    chk({tag, " busy_end"}, 32'(busy), 0);
    chk({tag, " settle_cycles"}, settle_cycles, 32'(exp_n));
    sc_out = int'(settle_cycles);
    @(negedge clk);
    chk({tag, " done_sticky"}, 32'(done), 32'(exp_done));
  endtask

  initial begin
    int  dc, sc;
    real tgt, tl, lim, fr, tau;
    reset = 1'b1; start = 1'b1; start2 = 1'b1;
    in_v = 0.0; target_v = 0.0; tol_v = 0.01;
    in2 = 0.0; target2 = 0.0; tol2 = 0.01;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst rst_req", 32'(rst_req | rst_req2), 0);
      chk("rst busy", 32'(busy | busy2), 0);
      chk("rst done", 32'(done | done2 | timed_out | timed_out2), 0);
      chk("rst settle", settle_cycles, 0);
      chk_real("rst sample", sample, 0.0);
    end
    reset = 1'b0; start = 1'b0; start2 = 1'b0;
    @(negedge clk);
    chk("idle busy", 32'(busy | rst_req), 0);

    // Constant input exactly on target.
    pre_val = 1.0; trk_vals = {1.0};
    measure("const", 1.0, 0.01, -1, dc, sc);
    chk("const start_to_done", 32'(dc), 32'(NPRE + NSET + 1));
    chk("const settle4", 32'(sc), 4);

    // Glitch restarts the streak.
    pre_val = 1.0; trk_vals = {1.0, 1.0, 1.0, 1.05, 1.0, 1.0, 1.0, 1.0};
    measure("glitch", 1.0, 0.01, -1, dc, sc);
    chk("glitch settle8", 32'(sc), 8);

    // First-order step, 1 MHz pole sampled at 100 MHz, released when rst_req drops.
    tau = 1000.0 / (2.0 * 3.14159265358979);
    pre_val = 0.0; trk_vals = {};
    for (int i = 0; i < 200; i++) trk_vals.push_back(1.0 - $exp(-(10.0 * (i + 1)) / tau));
    measure("step", 1.0, 0.01, -1, dc, sc);
    chk("step settle_range", 32'(sc >= 74 && sc <= 78), 1);
    chk("step sample_close", 32'((sample - 1.0) <= 0.01 && (1.0 - sample) <= 0.01), 1);

    // NaN tolerance falls back to the floor; stray start inside TRACK is ignored.
    pre_val = 0.5; trk_vals = {0.5, 0.5 + 5e-7, 0.5, 0.5, 0.5};
    measure("nan_tol", 0.5, $bitstoreal(64'h7FF8000000000000), 1, dc, sc);
    pre_val = 3.0; trk_vals = {3.0, 3.0, 3.1, 3.0, 3.0, 3.0, 3.0};
    measure("stray_start", 3.0, 0.02, 2, dc, sc);

    for (int r = 0; r < 6; r++) begin
      tgt = real'(int'($urandom_range(0, 4000)) - 2000) / 1000.0;
      case (r % 3)
        0:       tl = 0.001 * real'($urandom_range(1, 50));
        1:       tl = -0.5;
        default: tl = 0.0;
      endcase
      lim = (tl > 1e-6) ? tl : 1e-6;
      pre_val = tgt + real'($urandom_range(0, 100)) / 100.0;
      trk_vals = {};
      for (int i = 0; i < 40; i++) begin
        fr = real'($urandom_range(0, 1000)) / 1000.0;
        if ($urandom_range(0, 99) < 75) trk_vals.push_back(tgt + lim * (fr * 1.8 - 0.9));
        else if (fr < 0.5)              trk_vals.push_back(tgt + lim * (2.0 + fr));
        else                            trk_vals.push_back(tgt - lim * (2.0 + fr));
      end
      measure($sformatf("rand%0d", r), tgt, tl, int'($urandom_range(0, 3)), dc, sc);
    end

    // Timeout on the short-timeout instance.
    target2 = 2.0; tol2 = 0.01; in2 = 1.0; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    repeat (NPRE) @(negedge clk);
    for (int i = 0; i < NTO2; i++) begin
      chk("to pending", 32'(timed_out2), 0);
      chk("to busy", 32'(busy2), 1);
      @(negedge clk);
    end
    chk("to timed_out", 32'(timed_out2), 1);
    chk("to done", 32'(done2), 0);
    chk("to busy_end", 32'(busy2), 0);
    chk("to settle", settle_cycles2, 32'(NTO2));

    // Reset in the first precharge cycle.
    start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    chk("midrst rst_req_before", 32'(rst_req2), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst rst_req", 32'(rst_req2), 0);
    chk("midrst busy", 32'(busy2), 0);
    chk("midrst flags", 32'(done2 | timed_out2), 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst idle", 32'(rst_req2 | busy2 | done2), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
